// File: rtl/sync_filter.sv
// sync_filter: multi-channel synchronizer with a per-channel stability filter
// and registered rise/fall strobes.
//
// Each bit of i_async is brought into the clk domain through an NSync-stage
// flip-flop chain. The synchronized value must differ from the current
// filtered level for FilterLen consecutive cycles before it is accepted onto
// o_level. Any return to the current level before acceptance restarts the
// count from zero.
//
// Parameters:
//   NSync      - synchronizer stages per bit (>= 2)
//   Width      - number of independent channels (>= 1)
//   FilterLen  - cycles a new value must hold before acceptance (>= 1)
//   ResetValue - reset level of the sync stages and of o_level
//
// Ports:
//   clk     - the single clock
//   rst     - synchronous, active-high reset (has priority over i_hold)
//   i_async - asynchronous level inputs, one per channel
//   i_hold  - freezes filter counters and o_level, forces strobes low;
//             the sync chain keeps running
//   o_level - filtered, synchronized level
//   o_rise  - one-cycle strobe per channel when o_level goes 0->1
//   o_fall  - one-cycle strobe per channel when o_level goes 1->0
//
// Build option:
//   SYNC_FILTER_EDGE_EN - when defined, the o_rise/o_fall strobe registers are
//                         built; when undefined, both outputs are tied to 0.

module sync_filter #(
  parameter int unsigned     NSync      = 2,
  parameter int unsigned     Width      = 1,
  parameter int unsigned     FilterLen  = 4,
  parameter logic [Width-1:0] ResetValue = {Width{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] i_async,
  input  logic             i_hold,
  output logic [Width-1:0] o_level,
  output logic [Width-1:0] o_rise,
  output logic [Width-1:0] o_fall
);

  // Counter only needs to reach FilterLen-1; keep at least one bit.
  localparam int unsigned CntWRaw = $clog2(FilterLen + 1);
  localparam int unsigned CntW    = (CntWRaw < 1) ? 1 : CntWRaw;
  localparam logic [CntW-1:0] CntMax = CntW'(FilterLen - 1);

  // ---------------------------------------------------------------------------
  // Synchronizer chain
  // ---------------------------------------------------------------------------
  logic [Width-1:0] sync_q [NSync];
  logic [Width-1:0] sync_d [NSync];
  logic [Width-1:0] raw_c;

  // Shift the asynchronous inputs one stage per cycle.
  always_comb begin
    sync_d[0] = i_async;
    for (int unsigned i = 1; i < NSync; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NSync; i++) begin
        sync_q[i] <= ResetValue;
      end
    end else begin
      for (int unsigned i = 0; i < NSync; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign raw_c = sync_q[NSync-1];

  // ---------------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------------
  logic [CntW-1:0]  cnt_q [Width];
  logic [CntW-1:0]  cnt_d [Width];
  logic [Width-1:0] level_q;
  logic [Width-1:0] level_d;

  // Per-channel count of consecutive cycles where raw differs from the level.
  always_comb begin
    level_d = level_q;
    for (int unsigned c = 0; c < Width; c++) begin
      cnt_d[c] = cnt_q[c];
    end

    if (!i_hold) begin
      for (int unsigned c = 0; c < Width; c++) begin
        if (raw_c[c] == level_q[c]) begin
          // Agreement discards any partial count.
          cnt_d[c] = '0;
        end else if (cnt_q[c] == CntMax) begin
          level_d[c] = raw_c[c];
          cnt_d[c]   = '0;
        end else begin
          cnt_d[c] = cnt_q[c] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= ResetValue;
      for (int unsigned c = 0; c < Width; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int unsigned c = 0; c < Width; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign o_level = level_q;

  // ---------------------------------------------------------------------------
  // Edge strobes
  // ---------------------------------------------------------------------------
`ifdef SYNC_FILTER_EDGE_EN
  logic [Width-1:0] rise_q;
  logic [Width-1:0] rise_d;
  logic [Width-1:0] fall_q;
  logic [Width-1:0] fall_d;

  // level_d only differs from level_q on an acceptance, so the strobe lines
  // up with the first cycle the new level is visible. Hold keeps level_d equal
  // to level_q, which also keeps the strobes low.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    rise_d = level_d & ~level_q;
    fall_d = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;
`else
  assign o_rise = '0;
  assign o_fall = '0;
`endif

endmodule

// File: tb/tb_sync_filter.sv
// Directed testbench for sync_filter with NSync=2, Width=4, FilterLen=4,
// ResetValue=0. Strobe expectations follow SYNC_FILTER_EDGE_EN: with the
// macro undefined both strobes must stay 0 while o_level timing is unchanged.

module tb_sync_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_async;
  logic       i_hold;
  logic [3:0] o_level;
  logic [3:0] o_rise;
  logic [3:0] o_fall;

  int checks = 0;
  int errors = 0;

`ifdef SYNC_FILTER_EDGE_EN
  localparam logic [3:0] EdgeMask = 4'hF;
`else
  localparam logic [3:0] EdgeMask = 4'h0;
`endif

  sync_filter #(
    .NSync     (2),
    .Width     (4),
    .FilterLen (4),
    .ResetValue(4'h0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_async(i_async),
    .i_hold (i_hold),
    .o_level(o_level),
    .o_rise (o_rise),
    .o_fall (o_fall)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] lv,
                     input logic [3:0] rs, input logic [3:0] fl);
    logic [3:0] rs_e;
    logic [3:0] fl_e;
    rs_e = rs & EdgeMask;
    fl_e = fl & EdgeMask;
    checks++;
    assert (o_level === lv) else begin
      errors++;
      $error("FAIL %s level got %h exp %h", tag, o_level, lv);
    end
    checks++;
    assert (o_rise === rs_e) else begin
      errors++;
      $error("FAIL %s rise got %h exp %h", tag, o_rise, rs_e);
    end
    checks++;
    assert (o_fall === fl_e) else begin
      errors++;
      $error("FAIL %s fall got %h exp %h", tag, o_fall, fl_e);
    end
  endtask

  initial begin
    // Clean step: all channels high through reset, accepted on edge 5 after
    // the first post-reset capture (edge 0).
    rst     = 1'b1;
    i_async = 4'hF;
    i_hold  = 1'b0;
    repeat (3) tick();
    chk("reset", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      chk($sformatf("step_%0d", j), (j >= 5) ? 4'hF : 4'h0,
          (j == 5) ? 4'hF : 4'h0, 4'h0);
    end

    // Back to a clean all-low state.
    rst     = 1'b1;
    i_async = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset2", 4'h0, 4'h0, 4'h0);

    // Three-cycle glitch on channel 0 is rejected.
    for (int j = 0; j < 10; j++) begin
      i_async = (j < 3) ? 4'h1 : 4'h0;
      tick();
      chk($sformatf("glitch3_%0d", j), 4'h0, 4'h0, 4'h0);
    end

    // Four-cycle pulse on channel 0 passes as a four-cycle level pulse.
    for (int j = 0; j < 12; j++) begin
      i_async = (j < 4) ? 4'h1 : 4'h0;
      tick();
      chk($sformatf("pulse4_%0d", j), (j >= 5 && j <= 8) ? 4'h1 : 4'h0,
          (j == 5) ? 4'h1 : 4'h0, (j == 9) ? 4'h1 : 4'h0);
    end

    // Bounce on channel 1: 1,1,0,1,1,... accepted 4 filter cycles after the
    // last 0->1, i.e. on edge 8.
    for (int j = 0; j < 11; j++) begin
      i_async = (j == 2) ? 4'h0 : 4'h2;
      tick();
      chk($sformatf("bounce_%0d", j), (j >= 8) ? 4'h2 : 4'h0,
          (j == 8) ? 4'h2 : 4'h0, 4'h0);
    end

    // Hold on channel 2 after two counted cycles, for five edges; acceptance
    // lands on the second edge after release.
    for (int j = 0; j < 13; j++) begin
      i_async = 4'h6;
      i_hold  = (j >= 4 && j <= 8);
      tick();
      chk($sformatf("hold_%0d", j), (j >= 10) ? 4'h6 : 4'h2,
          (j == 10) ? 4'h4 : 4'h0, 4'h0);
    end
    i_hold = 1'b0;

    // Reset mid-filter, one edge before acceptance on channel 3.
    rst     = 1'b1;
    i_async = 4'h0;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset3", 4'h0, 4'h0, 4'h0);
    for (int j = 0; j < 12; j++) begin
      i_async = 4'h8;
      rst     = (j == 4);
      tick();
      chk($sformatf("midrst_%0d", j), (j >= 10) ? 4'h8 : 4'h0,
          (j == 10) ? 4'h8 : 4'h0, 4'h0);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
